// File: rtl/mux_pkg.sv
// Shared constants, index type and a constant-evaluable clog2 for the N:1 stream mux.
package mux_pkg;

  localparam int MAX_NUM_IN = 16;
  localparam int LEAF_RADIX = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  localparam int CHAN_IDX_W = clog2(MAX_NUM_IN);

  typedef logic [CHAN_IDX_W-1:0] chan_idx_t;

endpackage

// File: rtl/mux_leaf4.sv
// Combinational 4:1 word selector; the leaf cell of the stream mux select tree.
module mux_leaf4
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [LEAF_RADIX*DATA_W-1:0] data_i,
  input  logic [1:0]                   sel_i,
  output logic [DATA_W-1:0]            data_o
);

  always_comb begin
    case (sel_i)
      2'd0:    data_o = data_i[0*DATA_W +: DATA_W];
      2'd1:    data_o = data_i[1*DATA_W +: DATA_W];
      2'd2:    data_o = data_i[2*DATA_W +: DATA_W];
      default: data_o = data_i[3*DATA_W +: DATA_W];
    endcase
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// Define MUX_NX1_ROUND_ROBIN_EN to add the rr_mode port and round-robin arbitration.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter  int NUM_IN = 5,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [SEL_W-1:0]         sel,
`ifdef MUX_NX1_ROUND_ROBIN_EN
  input  logic                     rr_mode,
`endif
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         out_chan,
  output logic                     sel_err
);

  localparam int NUM_LEAF = (NUM_IN + LEAF_RADIX - 1) / LEAF_RADIX;
  localparam int PAD_W    = NUM_LEAF * LEAF_RADIX * DATA_W;
  localparam logic [SEL_W:0] NUM_IN_CMP = (SEL_W+1)'(NUM_IN);

  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic [SEL_W-1:0]  out_chan_q, out_chan_d;
  logic              sel_err_q, sel_err_d;

  logic              space;
  logic              sel_in_range;
  logic              accept;
  chan_idx_t         grant_idx;
  logic              grant_ok;

  assign space        = ~out_valid_q | out_ready;
  assign sel_in_range = {1'b0, sel} < NUM_IN_CMP;

`ifdef MUX_NX1_ROUND_ROBIN_EN
  localparam logic [CHAN_IDX_W:0] NUM_IN_EXT = (CHAN_IDX_W+1)'(NUM_IN);

  logic [SEL_W-1:0]    last_grant_q, last_grant_d;
  logic [CHAN_IDX_W:0] rr_sum, rr_cand;
  chan_idx_t           rr_try, rr_idx;
  logic                rr_found;

  // Walk upward from the channel after last_grant, wrapping at NUM_IN.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    rr_cand  = '0;
    rr_try   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      rr_sum  = {1'b0, chan_idx_t'(last_grant_q)} + (CHAN_IDX_W+1)'(k);
      rr_cand = (rr_sum >= NUM_IN_EXT) ? rr_sum - NUM_IN_EXT : rr_sum;
      rr_try  = chan_idx_t'(rr_cand);
      if (!rr_found && in_valid[rr_try[SEL_W-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_try;
      end
    end
  end

  assign last_grant_d = accept ? grant_idx[SEL_W-1:0] : last_grant_q;

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= SEL_W'(NUM_IN - 1);
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_comb begin
    grant_idx = chan_idx_t'(sel);
    grant_ok  = sel_in_range;
    sel_err_d = ~sel_in_range & (|in_valid);
`ifdef MUX_NX1_ROUND_ROBIN_EN
    if (rr_mode) begin
      grant_idx = rr_idx;
      grant_ok  = rr_found;
      sel_err_d = 1'b0;
    end
`endif
  end

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    in_ready = '0;
    if (space && grant_ok && !rst) in_ready[grant_idx[SEL_W-1:0]] = 1'b1;
  end

  assign accept = |(in_ready & in_valid);

  // Zero-padding ties off the unused inputs of the last leaf.
  logic [PAD_W-1:0]  padded_data;
  logic [DATA_W-1:0] leaf_out [NUM_LEAF];
  logic [DATA_W-1:0] tree_data;
  logic [1:0]        leaf_sel;

  assign padded_data = PAD_W'(in_data);
  assign leaf_sel    = grant_idx[CHAN_IDX_W-1:2];

  for (genvar g = 0; g < NUM_LEAF; g++) begin : g_leaf
    mux_leaf4 #(.DATA_W(DATA_W)) u_leaf (
      .data_i(padded_data[g*LEAF_RADIX*DATA_W +: LEAF_RADIX*DATA_W]),
      .sel_i (grant_idx[1:0]),
      .data_o(leaf_out[g])
    );
  end

  always_comb begin
    tree_data = '0;
    for (int j = 0; j < NUM_LEAF; j++) begin
      if (leaf_sel == 2'(j)) tree_data = leaf_out[j];
    end
  end

  // A new word may replace a draining one in the same cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      out_data_d  = tree_data;
      out_chan_d  = grant_idx[SEL_W-1:0];
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Self-checking bench for mux_nx1_stream (NUM_IN=5, DATA_W=8): vector table,
// directed corner sequences and randomized traffic against a behavioural model.
module tb_mux_nx1_stream;

  localparam int N  = 5;
  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_chan;
  logic          sel_err;
  logic          rr_mode = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mux_nx1_stream #(.NUM_IN(N), .DATA_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
`ifdef MUX_NX1_ROUND_ROBIN_EN
    .rr_mode  (rr_mode),
`endif
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_chan (out_chan),
    .sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state of the output stage plus a word queue.
  int m_valid = 0, m_data = 0, m_chan = 0, m_err = 0, m_last = N - 1;
  int sb[$];

  function automatic int m_target();
    if (rr_mode) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (in_valid[c]) return c;
      end
      return -1;
    end
    return (int'(sel) < N) ? int'(sel) : -1;
  endfunction

  // Check in_ready before the edge, advance the model, then check registered outputs.
  task automatic tick();
    int tgt;
    logic [N-1:0] exp_ready;
    logic acc;
    #1;
    tgt = m_target();
    exp_ready = '0;
    if ((m_valid == 0 || out_ready) && !rst && tgt >= 0) exp_ready[tgt] = 1'b1;
    check("in_ready", in_ready, exp_ready);
    acc = (exp_ready & in_valid) != 0;
    if (!rst && m_valid != 0 && out_ready && sb.size() > 0)
      check("sb_drain", {out_chan, out_data}, sb.pop_front());
    if (rst) begin
      m_valid = 0; m_data = 0; m_chan = 0; m_err = 0; m_last = N - 1;
      sb.delete();
    end else begin
      if (acc) begin
        m_valid = 1;
        m_data  = in_data[tgt*W +: W];
        m_chan  = tgt;
        m_last  = tgt;
        sb.push_back(m_chan * 256 + m_data);
      end else if (out_ready) begin
        m_valid = 0;
      end
      m_err = (!rr_mode && int'(sel) >= N && in_valid != 0) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("out_data", out_data, m_data);
    check("out_chan", out_chan, m_chan);
    check("sel_err", sel_err, m_err);
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [4:0] valid;
    logic       ordy;
    logic [4:0] e_ready;
    logic       e_valid;
    logic [7:0] e_data;
    logic [2:0] e_chan;
    logic       e_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{3'd0, 5'b11111, 1'b1, 5'b00001, 1'b1, 8'h10, 3'd0, 1'b0};
    vecs[1] = '{3'd1, 5'b11111, 1'b1, 5'b00010, 1'b1, 8'h21, 3'd1, 1'b0};
    vecs[2] = '{3'd2, 5'b11111, 1'b1, 5'b00100, 1'b1, 8'h32, 3'd2, 1'b0};
    vecs[3] = '{3'd3, 5'b11111, 1'b1, 5'b01000, 1'b1, 8'h43, 3'd3, 1'b0};
    vecs[4] = '{3'd4, 5'b11111, 1'b1, 5'b10000, 1'b1, 8'h54, 3'd4, 1'b0};
    vecs[5] = '{3'd6, 5'b00100, 1'b1, 5'b00000, 1'b0, 8'h54, 3'd4, 1'b1};
    vecs[6] = '{3'd6, 5'b00000, 1'b1, 5'b00000, 1'b0, 8'h54, 3'd4, 1'b0};

    in_data   = {8'h54, 8'h43, 8'h32, 8'h21, 8'h10};
    in_valid  = '1;
    out_ready = 1'b1;
    sel       = '0;

    // Reset held for three cycles with every channel offering data.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_sel_err", sel_err, 1'b0);
    end
    rst = 1'b0;

    // Basic select stepping and out-of-range select.
    for (int i = 0; i < 7; i++) begin
      sel       = vecs[i].sel;
      in_valid  = vecs[i].valid;
      out_ready = vecs[i].ordy;
      #1;
      check("vec_in_ready", in_ready, vecs[i].e_ready);
      tick();
      check("vec_out_valid", out_valid, vecs[i].e_valid);
      check("vec_out_data", out_data, vecs[i].e_data);
      check("vec_out_chan", out_chan, vecs[i].e_chan);
      check("vec_sel_err", sel_err, vecs[i].e_err);
    end

    // Backpressure: word held while stalled, then replaced on the releasing cycle.
    sel = 3'd2; in_valid = 5'b00100; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("bp_hold_data", out_data, 8'h32);
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_in_ready", in_ready, 5'b00000);
    in_data[2*W +: W] = 8'h77;
    out_ready = 1'b1;
    tick();
    check("bp_release_data", out_data, 8'h77);
    in_data[2*W +: W] = 8'h32;

    // Reset while a stalled word is held drops it; traffic then resumes.
    sel = 3'd3; in_valid = '1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    check("mid_hold_data", out_data, 8'h43);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_data", out_data, 8'h00);
    rst = 1'b0; out_ready = 1'b1; sel = 3'd1;
    tick();
    check("resume_data", out_data, 8'h21);
    check("resume_valid", out_valid, 1'b1);

`ifdef MUX_NX1_ROUND_ROBIN_EN
    begin
      int exp_a[5] = '{0, 2, 4, 0, 2};
      int exp_b[3] = '{0, 4, 0};
      rst = 1'b1; tick(); rst = 1'b0;
      rr_mode = 1'b1; in_valid = 5'b10101; out_ready = 1'b1; sel = 3'd6;
      for (int i = 0; i < 5; i++) begin
        tick();
        check("rr_grant", out_chan, exp_a[i]);
        check("rr_sel_err", sel_err, 1'b0);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
        tick();
        check("rr_drop_grant", out_chan, exp_b[i]);
        in_valid = 5'b10001;
      end
    end
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      in_data   = {$urandom, $urandom};
      in_valid  = N'($urandom);
      sel       = SW'($urandom_range(0, 7));
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 50) == 0;
`ifdef MUX_NX1_ROUND_ROBIN_EN
      rr_mode   = $urandom % 2 == 1;
`endif
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
